// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and default sizing for the SPI slave controller.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    localparam int SPI_WIDTH       = 8;
    localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: multi-flop synchroniser for one asynchronous pin with rise/fall strobes.
module spi_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic clear,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: mode-0 SPI slave sequencer; shifts words in/out on synchronised sclk edges
// and hands received words to the core over a valid/ready handshake.
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int WIDTH       = SPI_WIDTH,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             sclk,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_req,
    output logic             overrun,
    output logic             frame_err,
    output logic             busy
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
    logic             sclk_lvl_unused, cs_lvl_unused;
    logic [1:0]       mosi_edge_unused;
    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             got_bit_q, got_bit_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             miso_q, miso_d;
    logic             rx_valid_q, rx_valid_d;
    logic             tx_req_q, tx_req_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .clear(clear), .d(sclk),
        .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(clk), .clear(clear), .d(cs),
        .q(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(clk), .clear(clear), .d(mosi),
        .q(mosi_s), .rise(mosi_edge_unused[0]), .fall(mosi_edge_unused[1])
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        got_bit_d   = got_bit_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        miso_d      = miso_q;
        rx_valid_d  = rx_valid_q && !rx_ready;
        tx_req_d    = 1'b0;
        overrun_d   = overrun_q;
        frame_err_d = 1'b0;
        if (state_q == IDLE) begin
            if (cs_fall) begin
                state_d    = ACTIVE;
                cnt_d      = '0;
                got_bit_d  = 1'b0;
                rx_shift_d = '0;
                tx_shift_d = tx_data;
                miso_d     = tx_data[WIDTH-1];
                tx_req_d   = 1'b1;
            end
        end else begin
            if (sclk_rise) begin
                rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
                got_bit_d  = 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d      = '0;
                    rx_data_d  = rx_shift_d;
                    overrun_d  = overrun_q | rx_valid_d;
                    rx_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            // cs_rise sees the counter after this cycle's rise, so a word finishing now is not an error
            if (cs_rise) begin
                frame_err_d = (cnt_d != '0);
                state_d     = IDLE;
                cnt_d       = '0;
                miso_d      = 1'b0;
            end else if (sclk_fall) begin
                if (cnt_q != '0) begin
                    tx_shift_d = tx_shift_q << 1;
                    miso_d     = tx_shift_q[WIDTH-2];
                end else if (got_bit_q) begin
                    tx_shift_d = tx_data;
                    miso_d     = tx_data[WIDTH-1];
                    tx_req_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            got_bit_q   <= 1'b0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            miso_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            got_bit_q   <= got_bit_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            miso_q      <= miso_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign miso      = miso_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_req    = tx_req_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: SPI master driver with a word-level scoreboard for spi_slave_ctrl.
module tb_spi_slave_ctrl;
    logic       clk = 1'b0, clear = 1'b1, sclk = 1'b0, cs = 1'b1, mosi = 1'b0, rx_ready = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       miso, rx_valid, tx_req, overrun, frame_err, busy;
    logic [7:0] rx_data;

    int         tests = 0, fails = 0, txreq_cnt = 0, ferr_cnt = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovr = 1'b0;
    logic [7:0] f_rx[$], f_tx[$];

    always #5 clk = ~clk;

    spi_slave_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .clear(clear), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_data(tx_data),
        .tx_req(tx_req), .overrun(overrun), .frame_err(frame_err), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts strobes and pops the scoreboard on every accepted word
    always @(negedge clk) begin
        if (clear) begin
            if (tx_req) txreq_cnt++;
            if (frame_err) ferr_cnt++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rx_unexpected: got word %0h, none expected", rx_data);
                end else begin
                    chk("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int half();
        return int'($urandom_range(4, 6));
    endfunction

    task automatic wait_txreq(input int prev);
        int k = 0;
        while (txreq_cnt == prev && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("tx_req_seen", {31'h0, txreq_cnt != prev}, 32'h1);
    endtask

    // A word the master just finished: a stalled reader only ever sees the newest one
    task automatic push_exp(input logic [7:0] w);
        if (!rx_ready && exp_q.size() > 0) begin
            exp_q[exp_q.size()-1] = w;
            exp_ovr = 1'b1;
        end else begin
            exp_q.push_back(w);
        end
    endtask

    task automatic send_frame(input int nbits);
        int         tr0, fe0, w, pr;
        logic [7:0] mw = 8'h00;
        tr0 = txreq_cnt;
        fe0 = ferr_cnt;
        tx_data = f_tx[0];
        wait_cyc(2);
        cs = 1'b0;
        wait_txreq(tr0);
        tx_data = f_tx[1];
        chk("busy_active", {31'h0, busy}, 32'h1);
        wait_cyc(half());
        for (int b = 0; b < nbits; b++) begin
            w = b / 8;
            mosi = f_rx[w][7-(b%8)];
            wait_cyc(half());
            mw = {mw[6:0], miso};
            sclk = 1'b1;
            if (b % 8 == 7) push_exp(f_rx[w]);
            wait_cyc(half());
            pr = txreq_cnt;
            sclk = 1'b0;
            if (b == nbits - 1) cs = 1'b1;
            if (b % 8 == 7) begin
                chk("miso_word", {24'h0, mw}, {24'h0, f_tx[w]});
                if (b != nbits - 1) begin
                    wait_txreq(pr);
                    tx_data = f_tx[w+2];
                end
            end
        end
        if (nbits == 0) begin
            wait_cyc(half());
            cs = 1'b1;
        end
        wait_cyc(10);
        chk("busy_idle", {31'h0, busy}, 32'h0);
        chk("tx_req_count", txreq_cnt - tr0, 1 + (nbits > 0 ? (nbits - 1) / 8 : 0));
        chk("frame_err_count", ferr_cnt - fe0, {31'h0, (nbits % 8) != 0});
        chk("overrun", {31'h0, overrun}, {31'h0, exp_ovr});
    endtask

    // Random payloads with one spare tx entry beyond the last word slot
    task automatic build(input int nbits);
        f_rx.delete();
        f_tx.delete();
        for (int i = 0; i < (nbits + 7) / 8 + 2; i++) begin
            f_rx.push_back(8'($urandom));
            f_tx.push_back(8'($urandom));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        #2;
        clear = 1'b0;
        wait_cyc(3);
        chk("reset_outputs", {18'h0, rx_data, rx_valid, miso, tx_req, overrun, frame_err, busy}, 32'h0);
        clear = 1'b1;
        wait_cyc(4);
        chk("idle_busy", {31'h0, busy}, 32'h0);

        f_rx = '{8'hA5, 8'h00};
        f_tx = '{8'h3C, 8'h00, 8'h00};
        send_frame(8);

        f_rx = '{8'h12, 8'h34};
        f_tx = '{8'h5A, 8'h81, 8'h00, 8'h00};
        send_frame(16);

        f_rx = '{8'hF0, 8'h00};
        f_tx = '{8'hC7, 8'h00, 8'h00};
        send_frame(5);
        f_rx = '{8'h0F, 8'h00};
        f_tx = '{8'h96, 8'h00, 8'h00};
        send_frame(8);

        f_rx = '{8'h00};
        f_tx = '{8'hE1, 8'h00};
        send_frame(0);

        rx_ready = 1'b0;
        f_rx = '{8'h55, 8'hAA};
        f_tx = '{8'h11, 8'h22, 8'h33, 8'h00};
        send_frame(16);
        chk("stall_valid", {31'h0, rx_valid}, 32'h1);
        chk("stall_data", {24'h0, rx_data}, 32'hAA);
        rx_ready = 1'b1;
        wait_cyc(4);
        chk("stall_cleared", {31'h0, rx_valid}, 32'h0);
        chk("overrun_sticky", {31'h0, overrun}, 32'h1);

        tx_data = 8'h99;
        wait_cyc(2);
        cs = 1'b0;
        wait_cyc(6);
        for (int b = 0; b < 3; b++) begin
            mosi = 1'($urandom);
            wait_cyc(5);
            sclk = 1'b1;
            wait_cyc(5);
            sclk = 1'b0;
        end
        wait_cyc(3);
        clear = 1'b0;
        #2;
        chk("midframe_reset", {18'h0, rx_data, rx_valid, miso, tx_req, overrun, frame_err, busy}, 32'h0);
        cs = 1'b1;
        mosi = 1'b0;
        exp_q.delete();
        exp_ovr = 1'b0;
        wait_cyc(4);
        clear = 1'b1;
        wait_cyc(6);
        chk("post_reset", {18'h0, rx_data, rx_valid, miso, tx_req, overrun, frame_err, busy}, 32'h0);
        f_rx = '{8'hC3, 8'h00};
        f_tx = '{8'h6B, 8'h00, 8'h00};
        send_frame(8);

        for (int i = 0; i < 8; i++) begin
            nb = int'($urandom_range(1, 24));
            build(nb);
            send_frame(nb);
        end

        wait_cyc(10);
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
- Sequences the SPI slave datapath from the system clock. Synchronises the sclk/cs/mosi pins and detects sclk edges.
- Drives the bit counter and the MSB-first receive shift register, and loads and shifts the transmit byte onto miso.
- Hands completed bytes to the core over a valid/ready handshake, with overrun and aborted-frame reporting.
- Sits between the external SPI pins and the command decoder.

Parameters:
- WIDTH, 8: bits per SPI word. Also sets the rx_data/tx_data width; the bit counter is clog2(WIDTH) bits.
- SYNC_STAGES, 2: flip-flop stages on each of sclk, cs and mosi. Minimum 2.

Ports:
- clk  input  1  system clock. Must be at least 4x the sclk frequency.
- clear  input  1  asynchronous, active-low reset.
- sclk  input  1  SPI clock pin, asynchronous to clk. SPI mode 0.
- cs  input  1  SPI chip select pin, active-low, asynchronous.
- mosi  input  1  SPI data in, asynchronous.
- miso  output  1  SPI data out. Driven MSB first.
- rx_data  output  WIDTH  last completed received word.
- rx_valid  output  1  rx_data holds an unconsumed word.
- rx_ready  input  1  core accepts rx_data when rx_valid and rx_ready are both high.
- tx_data  input  WIDTH  word to transmit in the next SPI word slot.
- tx_req  output  1  one-cycle pulse: tx_data was just sampled, present the next word.
- overrun  output  1  sticky: a word completed while rx_valid was still high.
- frame_err  output  1  one-cycle pulse: cs deasserted with a partial word.
- busy  output  1  high while in state ACTIVE.

Behaviour:
- Reset (clear low, asynchronous) forces:
  - state IDLE, bit counter 0, shift registers 0;
  - synchronisers to sclk=0 and cs=1;
  - rx_data=0, rx_valid=0, miso=0, tx_req=0, overrun=0, frame_err=0, busy=0.
- Synchroniser and edges:
  - sclk, cs and mosi each pass through SYNC_STAGES flops.
  - Registered previous values give single-cycle strobes sclk_rise, sclk_fall, cs_fall and cs_rise.
- FSM, state IDLE:
  - On cs_fall: counter=0, load tx shift register from tx_data, miso=tx_data[WIDTH-1], pulse tx_req, go to ACTIVE.
- FSM, state ACTIVE, on sclk_rise:
  - Shift synchronised mosi into rx_shift LSB (MSB-first overall).
  - If counter==WIDTH-1, the word is complete: counter wraps to 0.
  - Otherwise counter+1.
- FSM, state ACTIVE, on sclk_fall:
  - If counter!=0: shift the tx register left and drive miso from its new MSB.
  - If counter==0, this is the first fall after a word boundary: reload the tx register from tx_data, drive miso=tx_data[WIDTH-1], pulse tx_req.
  - The first fall of a frame (counter==0, no bit yet received) does not reload; it is ignored.
- FSM, state ACTIVE, on cs_rise:
  - If counter!=0, pulse frame_err the next cycle and discard the partial word.
  - In all cases go to IDLE, counter=0, miso=0.
  - A completed word on the same cycle as cs_rise is still delivered.
- Simultaneous strobes: cs_rise takes priority over sclk_fall; sclk_rise is processed first.
- Word delivery:
  - On the completing sclk_rise cycle, the next cycle has rx_data = the full word (including the bit just sampled) and rx_valid=1.
  - Latency from raw sclk edge to rx_valid: SYNC_STAGES+2 clk cycles.
- Handshake:
  - rx_valid stays high until a cycle with rx_ready=1, then clears the next cycle.
  - rx_data is stable while rx_valid=1.
  - If a new word completes while rx_valid=1 and no acceptance occurs that cycle: rx_data is overwritten with the new word, rx_valid stays 1, overrun is set.
  - Acceptance and completion in the same cycle: the new word is loaded, rx_valid stays 1, no overrun.
- overrun is cleared only by reset.
- busy=1 exactly while in state ACTIVE.
- cs toggling with no sclk edges: tx_req pulse on entry, no rx_valid, no frame_err.

Decomposition:
- Shared package spi_pkg holds:
  - the state encoding: IDLE=1'b0, ACTIVE=1'b1;
  - default constants SPI_WIDTH=8 and SPI_SYNC_STAGES=2.
- One natural sub-module, spi_pin_sync: the per-signal synchroniser plus rise/fall strobe generator. It is instantiated for sclk and cs; mosi uses the synchroniser only.

Test Plan:
- Reset held low mid-frame (after 3 bits), then released -> all outputs 0, state IDLE, next frame receives correctly.
- cs low, send 0xA5 MSB-first with rx_ready=1, tx_data=0x3C -> rx_data=0xA5 with a one-cycle rx_valid; miso shows 0,0,1,1,1,1,0,0; one tx_req at cs_fall.
- Two back-to-back words 0x12, 0x34 in one frame, tx_data changed to 0x81 after the first tx_req -> rx_valid twice with 0x12 then 0x34; second miso word is 0x81; a second tx_req on the first sclk_fall after bit 8.
- rx_ready=0 while sending 0x55 then 0xAA -> rx_data=0xAA, rx_valid=1, overrun=1 and stays 1 after rx_ready rises.
- cs rises after 5 bits of 0xF0 -> frame_err single pulse, no rx_valid, busy=0; next full frame with 0x0F delivers 0x0F.
- cs falls and rises with no sclk -> tx_req one pulse, frame_err=0, rx_valid=0.
